btb_update_scheduler: RTL and testbench
=======================================

Name: btb_update_scheduler

Overview:
- Sits between the EX-stage branch resolution and the write/invalidate port of the branch target buffer.
- Buffers resolved taken branches in a small coalescing queue and drains them into the BTB one per cycle when the write port is free.
- Owns the BTB flush sequence: a sweep that invalidates every index while holding off fetch lookups.

Parameters:
ADDR_WIDTH, 26, width of PC and target fields
INDEX_WIDTH, 4, BTB index width; sweep covers 2**INDEX_WIDTH indices
QUEUE_DEPTH, 4, update queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
i_res_valid  in  1  branch resolution valid (EX stage)
i_res_taken  in  1  resolved branch was taken
i_res_pc  in  ADDR_WIDTH  branch PC
i_res_target  in  ADDR_WIDTH  resolved target
o_res_ready  out  1  queue can accept a resolution
i_flush_req  in  1  one-cycle pulse requesting full BTB invalidate
o_flush_busy  out  1  sweep in progress
i_btb_busy  in  1  BTB write port unavailable this cycle
o_btb_we  out  1  write head entry into BTB
o_btb_pc  out  ADDR_WIDTH  PC of entry being written (BTB derives tag/index)
o_btb_target  out  ADDR_WIDTH  target being written
o_btb_inval  out  1  clear valid bits of all ways at o_btb_index
o_btb_index  out  INDEX_WIDTH  index being invalidated
o_lookup_stall  out  1  fetch must not use BTB result this cycle

Behaviour:
- Reset: state RUN; queue empty; o_btb_we=0, o_btb_inval=0, o_btb_index=0, o_flush_busy=0, o_lookup_stall=0, o_res_ready=1, o_btb_pc/o_btb_target=0.
- States: RUN, SWEEP.
- RUN:
  - o_res_ready = !full.
  - Handshake: accept when i_res_valid && o_res_ready.
  - Accepted not-taken resolutions are consumed and discarded (no allocation).
  - Accepted taken resolution whose PC equals a queued entry's PC (excluding the entry popped this cycle): overwrite that entry's target in place. No new slot; order unchanged.
  - Otherwise push at tail.
- Drain:
  - o_btb_we = !empty && !i_btb_busy; o_btb_pc/o_btb_target = head; pop on o_btb_we.
  - Outputs are driven from registered queue state. An entry pushed in cycle N is written no earlier than N+1; no bypass.
  - Push and pop in the same cycle is allowed. When full, ready stays 0 even if a pop occurs.
- Flush:
  - i_flush_req in RUN: next cycle enter SWEEP.
  - Same cycle: all queue contents are discarded, and any resolution presented that cycle is dropped. Ready is forced 0 in that cycle.
- SWEEP:
  - o_btb_inval=1, o_flush_busy=1, o_lookup_stall=1, o_res_ready=0, o_btb_we=0.
  - o_btb_index steps 0,1,...,2**INDEX_WIDTH-1, one per cycle, ignoring i_btb_busy (invalidate has priority on the port).
  - After the last index, return to RUN with index counter 0. Sweep length is exactly 2**INDEX_WIDTH cycles.
  - i_flush_req during SWEEP is ignored (no restart).
- Wrap-around: queue head/tail pointers are modulo QUEUE_DEPTH with a separate count; full = count==QUEUE_DEPTH.
- Reset asserted mid-sweep or with a non-empty queue: immediate return to reset state. Pending updates are lost.

Decomposition:
- Package btb_sched_pkg:
  - btb_update_t struct {pc, target}
  - sched_state_e enum {RUN, SWEEP}
- Sub-module btb_update_queue: coalescing FIFO with push/pop, match-and-overwrite, full/empty/count.
- Top holds the FSM, sweep counter and port muxing.

Test Plan:
- Reset, then push taken pc=0x100 tgt=0x200 with i_btb_busy=0 -> next cycle o_btb_we=1, o_btb_pc=0x100, o_btb_target=0x200; queue empty after.
- i_btb_busy=1, push 4 distinct taken branches -> o_res_ready=0 after the 4th. Release busy -> 4 writes on consecutive cycles in push order.
- Busy held; push pc=0x40 tgt=0x80, then pc=0x40 tgt=0xC0 -> single entry. On release, one write with tgt=0xC0.
- Push not-taken pc=0x10 -> accepted, no write ever issued.
- Two entries queued, pulse i_flush_req -> 16 cycles of o_btb_inval with index 0..15, o_lookup_stall=1, no o_btb_we. Then RUN with empty queue and ready=1.
- Second i_flush_req at sweep index 5 -> sweep still ends after index 15. Assert rst_n=0 at index 8 -> next cycle o_flush_busy=0, o_btb_index=0.

Source files
------------

// File: rtl/btb_sched_pkg.sv
// Shared types for the BTB update scheduler: the queued update
// bundle and the scheduler state encoding.
package btb_sched_pkg;

    localparam int BTB_ADDR_WIDTH = 26;

    typedef struct packed {
        logic [BTB_ADDR_WIDTH-1:0] pc;
        logic [BTB_ADDR_WIDTH-1:0] target;
    } btb_update_t;

    typedef enum logic {
        RUN   = 1'b0,
        SWEEP = 1'b1
    } sched_state_e;

endpackage

// File: rtl/btb_update_queue.sv
// Coalescing update FIFO: a taken branch whose PC is already queued
// rewrites that entry's target instead of allocating a new slot.
module btb_update_queue
    import btb_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int PW          = $clog2(QUEUE_DEPTH),
    parameter int CW          = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  btb_update_t   push_entry,
    input  logic          pop,
    output btb_update_t   head_entry,
    output logic          empty,
    output logic [CW-1:0] count
);

    btb_update_t          mem [QUEUE_DEPTH];
    logic [PW-1:0]        head_ptr;
    logic [PW-1:0]        tail_ptr;
    logic                 hit;
    logic [PW-1:0]        hit_idx;
    logic [PW-1:0]        offs;
    logic                 alloc;
    logic                 upd;

    assign empty      = (count == '0);
    assign head_entry = mem[head_ptr];

    // The entry leaving this cycle is not a merge candidate.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        offs    = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            offs = PW'(i) - head_ptr;
            if (!hit && (CW'(offs) < count) &&
                !(pop && (offs == '0)) &&
                (mem[i].pc == push_entry.pc)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    assign alloc = push && !hit;
    assign upd   = push && hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (alloc) begin
                mem[tail_ptr] <= push_entry;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            if (upd) begin
                mem[hit_idx].target <= push_entry.target;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

endmodule

// File: rtl/btb_update_scheduler.sv
// Schedules resolved-branch writes into the BTB and owns the
// full-invalidate sweep that holds off fetch lookups.
module btb_update_scheduler
    import btb_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = BTB_ADDR_WIDTH,
    parameter int INDEX_WIDTH = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_res_valid,
    input  logic                   i_res_taken,
    input  logic [ADDR_WIDTH-1:0]  i_res_pc,
    input  logic [ADDR_WIDTH-1:0]  i_res_target,
    output logic                   o_res_ready,
    input  logic                   i_flush_req,
    output logic                   o_flush_busy,
    input  logic                   i_btb_busy,
    output logic                   o_btb_we,
    output logic [ADDR_WIDTH-1:0]  o_btb_pc,
    output logic [ADDR_WIDTH-1:0]  o_btb_target,
    output logic                   o_btb_inval,
    output logic [INDEX_WIDTH-1:0] o_btb_index,
    output logic                   o_lookup_stall
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    sched_state_e           state;
    sched_state_e           state_next;
    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic                   sweep_last;
    logic                   flush_now;
    logic                   push;
    logic                   pop;
    logic                   q_empty;
    logic                   q_full;
    logic [CW-1:0]          q_count;
    btb_update_t            head_entry;
    btb_update_t            push_entry;

    assign flush_now  = (state == RUN) && i_flush_req;
    assign sweep_last = &sweep_idx;
    assign q_full     = (q_count == CW'(QUEUE_DEPTH));
    assign push       = i_res_valid && o_res_ready && i_res_taken;
    assign pop        = o_btb_we;
    assign push_entry = '{pc: i_res_pc, target: i_res_target};

    btb_update_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush_now),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .empty      (q_empty),
        .count      (q_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_idx <= '0;
        end else if (state == SWEEP) begin
            sweep_idx <= sweep_last ? '0 : sweep_idx + 1'b1;
        end else begin
            sweep_idx <= '0;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (i_flush_req) state_next = SWEEP;
            SWEEP:   if (sweep_last) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A flush request discards the queue, so nothing drains that cycle.
    always_comb begin
        o_res_ready    = 1'b0;
        o_btb_we       = 1'b0;
        o_btb_inval    = 1'b0;
        o_flush_busy   = 1'b0;
        o_lookup_stall = 1'b0;
        unique case (state)
            RUN: begin
                o_res_ready = !q_full && !i_flush_req;
                o_btb_we    = !q_empty && !i_btb_busy && !i_flush_req;
            end
            SWEEP: begin
                o_btb_inval    = 1'b1;
                o_flush_busy   = 1'b1;
                o_lookup_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_btb_index  = sweep_idx;
    assign o_btb_pc     = q_empty ? '0 : head_entry.pc;
    assign o_btb_target = q_empty ? '0 : head_entry.target;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed and random stimulus for btb_update_scheduler against a
// queue-based reference model.
module tb_btb_update_scheduler;

    localparam int AW   = 26;
    localparam int IW   = 4;
    localparam int QD   = 4;
    localparam int NIDX = 1 << IW;

    logic          clk;
    logic          rst_n;
    logic          i_res_valid;
    logic          i_res_taken;
    logic [AW-1:0] i_res_pc;
    logic [AW-1:0] i_res_target;
    logic          o_res_ready;
    logic          i_flush_req;
    logic          o_flush_busy;
    logic          i_btb_busy;
    logic          o_btb_we;
    logic [AW-1:0] o_btb_pc;
    logic [AW-1:0] o_btb_target;
    logic          o_btb_inval;
    logic [IW-1:0] o_btb_index;
    logic          o_lookup_stall;

    btb_update_scheduler #(
        .ADDR_WIDTH  (AW),
        .INDEX_WIDTH (IW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_res_valid    (i_res_valid),
        .i_res_taken    (i_res_taken),
        .i_res_pc       (i_res_pc),
        .i_res_target   (i_res_target),
        .o_res_ready    (o_res_ready),
        .i_flush_req    (i_flush_req),
        .o_flush_busy   (o_flush_busy),
        .i_btb_busy     (i_btb_busy),
        .o_btb_we       (o_btb_we),
        .o_btb_pc       (o_btb_pc),
        .o_btb_target   (o_btb_target),
        .o_btb_inval    (o_btb_inval),
        .o_btb_index    (o_btb_index),
        .o_lookup_stall (o_lookup_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
    } ent_t;

    ent_t          mq[$];
    bit            m_sweep;
    int            m_pos;
    logic [AW-1:0] wr_pc[$];
    logic [AW-1:0] wr_tgt[$];
    int            errors = 0;
    int            checks = 0;
    int            n_busy = 0;
    int            mark;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance the model at posedge.
    task automatic step();
        bit   e_ready;
        bit   e_we;
        int   j;
        ent_t e;
        @(negedge clk);
        if (m_sweep) begin
            e_ready = 1'b0;
            e_we    = 1'b0;
        end else begin
            e_ready = (mq.size() < QD) && !i_flush_req;
            e_we    = (mq.size() > 0) && !i_btb_busy && !i_flush_req;
        end
        chk("ready", 64'(o_res_ready), 64'(e_ready));
        chk("we", 64'(o_btb_we), 64'(e_we));
        chk("inval", 64'(o_btb_inval), 64'(m_sweep));
        chk("flush_busy", 64'(o_flush_busy), 64'(m_sweep));
        chk("stall", 64'(o_lookup_stall), 64'(m_sweep));
        chk("index", 64'(o_btb_index), 64'(m_sweep ? m_pos : 0));
        if (e_we) begin
            chk("wr_pc", 64'(o_btb_pc), 64'(mq[0].pc));
            chk("wr_tgt", 64'(o_btb_target), 64'(mq[0].tgt));
        end
        if (o_btb_we === 1'b1) begin
            wr_pc.push_back(o_btb_pc);
            wr_tgt.push_back(o_btb_target);
        end
        if (o_flush_busy === 1'b1) n_busy++;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_sweep = 1'b0;
            m_pos   = 0;
        end else if (m_sweep) begin
            if (m_pos == NIDX - 1) begin
                m_sweep = 1'b0;
                m_pos   = 0;
            end else begin
                m_pos++;
            end
        end else if (i_flush_req) begin
            mq.delete();
            m_sweep = 1'b1;
            m_pos   = 0;
        end else begin
            if (i_res_valid && e_ready && i_res_taken) begin
                j = -1;
                for (int k = e_we ? 1 : 0; k < mq.size(); k++) begin
                    if (j < 0 && mq[k].pc == i_res_pc) j = k;
                end
                if (j >= 0) begin
                    mq[j].tgt = i_res_target;
                end else begin
                    e.pc  = i_res_pc;
                    e.tgt = i_res_target;
                    mq.push_back(e);
                end
            end
            if (e_we) void'(mq.pop_front());
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit t,
                         input logic [AW-1:0] pc,
                         input logic [AW-1:0] tgt);
        i_res_valid  = v;
        i_res_taken  = t;
        i_res_pc     = pc;
        i_res_target = tgt;
    endtask

    initial begin
        rst_n       = 1'b0;
        i_flush_req = 1'b0;
        i_btb_busy  = 1'b0;
        drive(0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_sweep = 1'b0;
        m_pos   = 0;
        rst_n   = 1'b1;

        chk("rst_ready", 64'(o_res_ready), 64'd1);
        chk("rst_we", 64'(o_btb_we), 64'd0);
        chk("rst_inval", 64'(o_btb_inval), 64'd0);
        chk("rst_index", 64'(o_btb_index), 64'd0);
        chk("rst_fbusy", 64'(o_flush_busy), 64'd0);
        chk("rst_stall", 64'(o_lookup_stall), 64'd0);
        chk("rst_pc", 64'(o_btb_pc), 64'd0);
        chk("rst_tgt", 64'(o_btb_target), 64'd0);

        // single write, one cycle after push
        drive(1, 1, 26'h100, 26'h200);
        mark = wr_pc.size();
        step();
        drive(0, 0, '0, '0);
        chk("t1_no_bypass", 64'(wr_pc.size()), 64'(mark));
        step();
        chk("t1_count", 64'(wr_pc.size()), 64'(mark + 1));
        if (wr_pc.size() == mark + 1) begin
            chk("t1_pc", 64'(wr_pc[mark]), 64'h100);
            chk("t1_tgt", 64'(wr_tgt[mark]), 64'h200);
        end
        chk("t1_empty", 64'(o_btb_we), 64'd0);
        step();

        // fill while busy, then drain in order
        i_btb_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 26'(32'h1000 + 4 * k), 26'(32'h2000 + 4 * k));
            step();
        end
        drive(0, 0, '0, '0);
        chk("t2_full_ready", 64'(o_res_ready), 64'd0);
        i_btb_busy = 1'b0;
        mark = wr_pc.size();
        repeat (4) step();
        chk("t2_count", 64'(wr_pc.size()), 64'(mark + 4));
        if (wr_pc.size() == mark + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t2_pc", 64'(wr_pc[mark + k]), 64'(32'h1000 + 4 * k));
                chk("t2_tgt", 64'(wr_tgt[mark + k]), 64'(32'h2000 + 4 * k));
            end
        end
        step();

        // coalescing
        i_btb_busy = 1'b1;
        drive(1, 1, 26'h40, 26'h80);
        step();
        drive(1, 1, 26'h40, 26'hC0);
        step();
        drive(0, 0, '0, '0);
        step();
        i_btb_busy = 1'b0;
        mark = wr_pc.size();
        repeat (3) step();
        chk("t3_count", 64'(wr_pc.size()), 64'(mark + 1));
        if (wr_pc.size() == mark + 1) begin
            chk("t3_pc", 64'(wr_pc[mark]), 64'h40);
            chk("t3_tgt", 64'(wr_tgt[mark]), 64'hC0);
        end

        // not-taken is consumed without a write
        drive(1, 0, 26'h10, 26'h99);
        chk("t4_ready", 64'(o_res_ready), 64'd1);
        mark = wr_pc.size();
        step();
        drive(0, 0, '0, '0);
        repeat (3) step();
        chk("t4_nowrite", 64'(wr_pc.size()), 64'(mark));

        // flush with two queued entries
        i_btb_busy = 1'b1;
        drive(1, 1, 26'h300, 26'h400);
        step();
        drive(1, 1, 26'h304, 26'h404);
        step();
        drive(0, 0, '0, '0);
        i_flush_req = 1'b1;
        step();
        i_flush_req = 1'b0;
        i_btb_busy  = 1'b0;
        mark = wr_pc.size();
        for (int k = 0; k < NIDX; k++) begin
            chk("t5_idx", 64'(o_btb_index), 64'(k));
            step();
        end
        chk("t5_nowrite", 64'(wr_pc.size()), 64'(mark));
        chk("t5_ready", 64'(o_res_ready), 64'd1);
        chk("t5_fbusy", 64'(o_flush_busy), 64'd0);
        chk("t5_empty", 64'(o_btb_we), 64'd0);
        step();

        // re-flush during sweep is ignored
        n_busy = 0;
        i_flush_req = 1'b1;
        step();
        i_flush_req = 1'b0;
        repeat (5) step();
        chk("t6_idx5", 64'(o_btb_index), 64'd5);
        i_flush_req = 1'b1;
        step();
        i_flush_req = 1'b0;
        repeat (10) step();
        step();
        chk("t6_len", 64'(n_busy), 64'(NIDX));

        // reset mid-sweep
        i_flush_req = 1'b1;
        step();
        i_flush_req = 1'b0;
        repeat (8) step();
        chk("t7_idx8", 64'(o_btb_index), 64'd8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t7_fbusy", 64'(o_flush_busy), 64'd0);
        chk("t7_index", 64'(o_btb_index), 64'd0);
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom % 2), 1'($urandom % 4 != 0),
                  26'(($urandom % 6) * 32'h40), 26'($urandom));
            i_btb_busy  = ($urandom % 3) == 0;
            i_flush_req = ($urandom % 150) == 0;
            rst_n       = ($urandom % 700) != 0;
            step();
        end
        rst_n = 1'b1;
        i_flush_req = 1'b0;
        drive(0, 0, '0, '0);
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
